// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter: owns the single write port of the register file.
// After reset, or on an init_req pulse, it sweeps INIT_VAL into every register.
// It then shares the write port among NREQ writeback requesters by round-robin.
//
// Ports
//   clk, rst_n   clock and asynchronous active-low reset
//   init_req     1-cycle pulse in RUN that restarts the init sweep
//   req          per-requester pending write
//   req_wn       packed register indices, requester i at [i*AW +: AW]
//   req_d        packed write data, requester i at [i*DW +: DW]
//   gnt          one-hot grant, combinational; a write is accepted on req[i] & gnt[i]
//   rf_we/rf_wn/rf_d  registered regfile write port
//   init_done    1 while in RUN
module regfile_wr_arbiter #(
    parameter int unsigned     NREQ     = 4,
    parameter int unsigned     DW       = 16,
    parameter int unsigned     AW       = 4,
    parameter int unsigned     NREGS    = 16,
    parameter logic [DW-1:0]   INIT_VAL = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 init_req,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*AW-1:0]   req_wn,
    input  logic [NREQ*DW-1:0]   req_d,
    output logic [NREQ-1:0]      gnt,
    output logic                 rf_we,
    output logic [AW-1:0]        rf_wn,
    output logic [DW-1:0]        rf_d,
    output logic                 init_done
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t          state;
    logic [AW-1:0]   cnt;
    logic [PW-1:0]   rr_ptr;

    logic            gnt_vld;
    logic [PW-1:0]   gnt_idx;
    int unsigned     idx;

    // Round-robin search starting at rr_ptr; suppressed outside RUN and on init_req.
    always_comb begin
        gnt     = '0;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        idx     = 0;
        if (state == ST_RUN && !init_req) begin
            for (int unsigned k = 0; k < NREQ; k++) begin
                idx = (32'(rr_ptr) + k) % NREQ;
                if (!gnt_vld && req[idx]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = PW'(idx);
                end
            end
            if (gnt_vld) begin
                gnt[gnt_idx] = 1'b1;
            end
        end
    end

    // State, sweep counter, round-robin pointer and registered write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_INIT;
            cnt       <= '0;
            rr_ptr    <= '0;
            rf_we     <= 1'b0;
            rf_wn     <= '0;
            rf_d      <= '0;
            init_done <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    // init_req is ignored here; the sweep always completes.
                    rf_we <= 1'b1;
                    rf_wn <= cnt;
                    rf_d  <= INIT_VAL;
                    if (cnt == AW'(NREGS - 1)) begin
                        cnt       <= '0;
                        state     <= ST_RUN;
                        init_done <= 1'b1;
                    end else begin
                        cnt <= cnt + AW'(1);
                    end
                end
                ST_RUN: begin
                    if (init_req) begin
                        state     <= ST_INIT;
                        cnt       <= '0;
                        init_done <= 1'b0;
                        rf_we     <= 1'b0;
                    end else if (gnt_vld) begin
                        rf_we  <= 1'b1;
                        rf_wn  <= req_wn[gnt_idx*AW +: AW];
                        rf_d   <= req_d[gnt_idx*DW +: DW];
                        rr_ptr <= (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + PW'(1);
                    end else begin
                        // Index and data hold their last values when idle.
                        rf_we <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_INIT;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// tb_regfile_wr_arbiter: directed bench for regfile_wr_arbiter (NREQ=4, DW=16, AW=4).
module tb_regfile_wr_arbiter;

    logic        clk;
    logic        rst_n;
    logic        init_req;
    logic [3:0]  req;
    logic [15:0] req_wn;
    logic [63:0] req_d;
    logic [3:0]  gnt;
    logic        rf_we;
    logic [3:0]  rf_wn;
    logic [15:0] rf_d;
    logic        init_done;

    int passes = 0;
    int total  = 0;

    regfile_wr_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .init_req  (init_req),
        .req       (req),
        .req_wn    (req_wn),
        .req_d     (req_d),
        .gnt       (gnt),
        .rf_we     (rf_we),
        .rf_wn     (rf_wn),
        .rf_d      (rf_d),
        .init_done (init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passes++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [3:0] wn, input logic [15:0] d);
        req_wn[i*4 +: 4]  = wn;
        req_d[i*16 +: 16] = d;
    endtask

    initial begin
        rst_n    = 1'b0;
        init_req = 1'b0;
        req      = '0;
        req_wn   = '0;
        req_d    = '0;

        // Reset state
        #12;
        chk("rst_we",   32'(rf_we), 32'd0);
        chk("rst_wn",   32'(rf_wn), 32'd0);
        chk("rst_d",    32'(rf_d), 32'd0);
        chk("rst_gnt",  32'(gnt), 32'd0);
        chk("rst_done", 32'(init_done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Power-on sweep: 16 writes of 0 to R0..R15
        for (int i = 0; i < 16; i++) begin
            tick();
            chk("sweep_we",   32'(rf_we), 32'd1);
            chk("sweep_wn",   32'(rf_wn), 32'(i));
            chk("sweep_d",    32'(rf_d), 32'h0);
            chk("sweep_gnt",  32'(gnt), 32'd0);
            chk("sweep_done", 32'(init_done), (i == 15) ? 32'd1 : 32'd0);
        end
        tick();
        chk("idle_we", 32'(rf_we), 32'd0);

        // All four requesting: 0001,0010,0100,1000 twice, one write per cycle
        for (int i = 0; i < 4; i++) set_req(i, 4'(4 + i), 16'(16'h0100 + i));
        req = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            #1;
            chk("rr_gnt", 32'(gnt), 32'(1 << (c % 4)));
            tick();
            chk("rr_we", 32'(rf_we), 32'd1);
            chk("rr_wn", 32'(rf_wn), 32'(4 + (c % 4)));
            chk("rr_d",  32'(rf_d), 32'(16'h0100 + (c % 4)));
        end
        req = '0;
        #1;
        chk("rr_idle_gnt", 32'(gnt), 32'd0);

        // Single requester 1: R2 <= 0009, 1-cycle latency
        set_req(1, 4'd2, 16'h0009);
        req = 4'b0010;
        #1;
        chk("single_gnt", 32'(gnt), 32'b0010);
        tick();
        req = '0;
        chk("single_we", 32'(rf_we), 32'd1);
        chk("single_wn", 32'(rf_wn), 32'd2);
        chk("single_d",  32'(rf_d), 32'h0009);
        tick();
        chk("hold_we", 32'(rf_we), 32'd0);
        chk("hold_wn", 32'(rf_wn), 32'd2);
        chk("hold_d",  32'(rf_d), 32'h0009);

        // rr_ptr is 2 here; grant requester 0 alone to move it to 1
        set_req(0, 4'd3, 16'h1111);
        req = 4'b0001;
        #1;
        chk("p0_gnt", 32'(gnt), 32'b0001);
        tick();
        req = '0;
        chk("p0_wn", 32'(rf_wn), 32'd3);

        // rr_ptr=1, req=0101: requester 2 first, then 0 (same target, last wins)
        set_req(0, 4'd9, 16'hAAAA);
        set_req(2, 4'd9, 16'hBBBB);
        req = 4'b0101;
        #1;
        chk("ord_gnt0", 32'(gnt), 32'b0100);
        tick();
        req = 4'b0001;
        chk("ord_wn0", 32'(rf_wn), 32'd9);
        chk("ord_d0",  32'(rf_d), 32'hBBBB);
        #1;
        chk("ord_gnt1", 32'(gnt), 32'b0001);
        tick();
        req = '0;
        chk("ord_we1", 32'(rf_we), 32'd1);
        chk("ord_d1",  32'(rf_d), 32'hAAAA);

        // init_req beats req[3]; sweep runs, init_req mid-sweep is ignored
        set_req(3, 4'hA, 16'h0055);
        req      = 4'b1000;
        init_req = 1'b1;
        #1;
        chk("ireq_gnt", 32'(gnt), 32'd0);
        tick();
        init_req = 1'b0;
        chk("ireq_we",   32'(rf_we), 32'd0);
        chk("ireq_done", 32'(init_done), 32'd0);
        for (int i = 0; i < 16; i++) begin
            tick();
            init_req = (i == 5);
            chk("resweep_we", 32'(rf_we), 32'd1);
            chk("resweep_wn", 32'(rf_wn), 32'(i));
            chk("resweep_d",  32'(rf_d), 32'h0);
            if (i < 15) chk("resweep_gnt", 32'(gnt), 32'd0);
        end
        chk("resweep_done", 32'(init_done), 32'd1);
        chk("first_run_gnt", 32'(gnt), 32'b1000);
        tick();
        req = '0;
        chk("first_run_wn", 32'(rf_wn), 32'hA);
        chk("first_run_d",  32'(rf_d), 32'h0055);

        // Reset mid-sweep at rf_wn=7, then the sweep restarts from 0
        init_req = 1'b1;
        tick();
        init_req = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        chk("pre_rst_wn", 32'(rf_wn), 32'd7);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_we",   32'(rf_we), 32'd0);
        chk("mid_rst_wn",   32'(rf_wn), 32'd0);
        chk("mid_rst_d",    32'(rf_d), 32'd0);
        chk("mid_rst_gnt",  32'(gnt), 32'd0);
        chk("mid_rst_done", 32'(init_done), 32'd0);
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("restart_we", 32'(rf_we), 32'd1);
            chk("restart_wn", 32'(rf_wn), 32'(i));
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
